hyper_eot_tracker: RTL and testbench

Downstream event stage for the HyperBus uDMA macro. It tracks outstanding HyperBus transfers in launch order, using the rx-channel (read) and tx-channel (write) start events. Each end-of-transfer pulse from the HyperBus controller is classified as a read-EOT or write-EOT event for the event/interrupt fabric. The block keeps an ordered direction queue, saturating completion counters and sticky error status, so that back-to-back transfers of mixed direction are classified correctly.

---
 rtl/hyper_eot_tracker.sv | 201 ++++++++++++++++++++
 tb/tb_hyper_eot_tracker.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hyper_eot_tracker.sv
// ---------------------------------------------------------------------------
// hyper_eot_tracker
//
// Purpose:
//   Tracks outstanding HyperBus transfers in launch order so that each
//   end-of-transfer pulse from the controller can be classified as a read
//   or a write completion. A small FIFO of direction bits (1 = read,
//   0 = write) is pushed on rx/tx start events and popped on eot_i.
//   Saturating completion counters and sticky error flags are kept for
//   software.
//
// Configuration:
//   HYPER_EOT_TRACK_CNT_EN - when defined, rd_cnt_o / wr_cnt_o are real
//   saturating counters; when undefined they are tied to 0 and the counter
//   registers do not exist.
//
// Ports:
//   sys_clk_i       sole clock, rising edge
//   rst_i           synchronous, active-high reset
//   rx_start_evt_i  pulse: read transfer launched
//   tx_start_evt_i  pulse: write transfer launched
//   eot_i           pulse: end of transfer (any channel)
//   clr_i           synchronous flush of queue, counters and status
//   rd_eot_evt_o    pulse: completed transfer was a read
//   wr_eot_evt_o    pulse: completed transfer was a write
//   err_evt_o       pulse: overflow or orphan EOT in the previous cycle
//   pending_o       number of queued outstanding transfers
//   rd_cnt_o        completed reads, saturating
//   wr_cnt_o        completed writes, saturating
//   status_o        sticky flags: [0] overflow, [1] orphan EOT
// ---------------------------------------------------------------------------
module hyper_eot_tracker #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic                     sys_clk_i,
    input  logic                     rst_i,
    input  logic                     rx_start_evt_i,
    input  logic                     tx_start_evt_i,
    input  logic                     eot_i,
    input  logic                     clr_i,
    output logic                     rd_eot_evt_o,
    output logic                     wr_eot_evt_o,
    output logic                     err_evt_o,
    output logic [$clog2(DEPTH):0]   pending_o,
    output logic [CNT_W-1:0]         rd_cnt_o,
    output logic [CNT_W-1:0]         wr_cnt_o,
    output logic [1:0]               status_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int OW = PW + 1;
    localparam logic [OW-1:0] DEPTH_OCC = OW'(DEPTH);

    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [OW-1:0]    occ_q, occ_d;
    logic [DEPTH-1:0] dir_q, dir_d;
    logic             rd_evt_q, rd_evt_d;
    logic             wr_evt_q, wr_evt_d;
    logic             err_evt_q, err_evt_d;
    logic [1:0]       status_q, status_d;

    logic             pop;
    logic             orphan;
    logic             head_is_rd;
    logic [OW-1:0]    free_slots;
    logic             push_rd;
    logic             push_wr;
    logic             overflow;
    logic [PW-1:0]    second_slot;

    // Pop decision uses the occupancy before this cycle's pushes, so an
    // eot arriving together with the first start is an orphan.
    assign pop        = eot_i && (occ_q != '0);
    assign orphan     = eot_i && (occ_q == '0);
    assign head_is_rd = dir_q[rd_ptr_q];

    // A pop in the same cycle frees its slot before the pushes are judged.
    assign free_slots = DEPTH_OCC - occ_q + OW'(pop);

    // Read is the older of two simultaneous starts, so it claims a slot first.
    assign push_rd  = rx_start_evt_i && (free_slots != '0);
    assign push_wr  = tx_start_evt_i &&
                      (rx_start_evt_i ? (free_slots >= OW'(2)) : (free_slots != '0));
    assign overflow = (rx_start_evt_i && !push_rd) || (tx_start_evt_i && !push_wr);

    assign second_slot = wr_ptr_q + PW'(push_rd);

    always_comb begin
        // NOTE: every signal gets a default first, so no path through this
        // block leaves a value unassigned and no latch is inferred.
        rd_ptr_d  = rd_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        occ_d     = occ_q;
        dir_d     = dir_q;
        rd_evt_d  = 1'b0;
        wr_evt_d  = 1'b0;
        err_evt_d = 1'b0;
        status_d  = status_q;

        if (clr_i) begin
            // Flush wins over everything this cycle; stale entries in dir_q
            // are unreachable once the pointers and occupancy are zero.
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            occ_d    = '0;
            status_d = '0;
        end else begin
            rd_evt_d  = pop && head_is_rd;
            wr_evt_d  = pop && !head_is_rd;
            err_evt_d = overflow || orphan;
            status_d  = status_q | {orphan, overflow};

            if (push_rd) begin
                dir_d[wr_ptr_q] = 1'b1;
            end
            if (push_wr) begin
                dir_d[second_slot] = 1'b0;
            end

            // Pointers wrap naturally because DEPTH is a power of two.
            wr_ptr_d = wr_ptr_q + PW'(push_rd) + PW'(push_wr);
            rd_ptr_d = rd_ptr_q + PW'(pop);
            occ_d    = occ_q - OW'(pop) + OW'(push_rd) + OW'(push_wr);
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the pre-edge value of every other flop.
    always_ff @(posedge sys_clk_i) begin
        if (rst_i) begin
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            occ_q     <= '0;
            rd_evt_q  <= 1'b0;
            wr_evt_q  <= 1'b0;
            err_evt_q <= 1'b0;
            status_q  <= '0;
        end else begin
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            occ_q     <= occ_d;
            rd_evt_q  <= rd_evt_d;
            wr_evt_q  <= wr_evt_d;
            err_evt_q <= err_evt_d;
            status_q  <= status_d;
        end
    end

    // NOTE: the direction storage is deliberately not reset; an entry is
    // only ever read after it has been written, since occupancy gates pops.
    always_ff @(posedge sys_clk_i) begin
        dir_q <= dir_d;
    end

`ifdef HYPER_EOT_TRACK_CNT_EN
    logic [CNT_W-1:0] rd_cnt_q, rd_cnt_d;
    logic [CNT_W-1:0] wr_cnt_q, wr_cnt_d;

    always_comb begin
        rd_cnt_d = rd_cnt_q;
        wr_cnt_d = wr_cnt_q;
        if (clr_i) begin
            rd_cnt_d = '0;
            wr_cnt_d = '0;
        end else begin
            // Counters stick at all-ones instead of wrapping.
            if (rd_evt_d && (rd_cnt_q != '1)) begin
                rd_cnt_d = rd_cnt_q + CNT_W'(1);
            end
            if (wr_evt_d && (wr_cnt_q != '1)) begin
                wr_cnt_d = wr_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge sys_clk_i) begin
        if (rst_i) begin
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
        end else begin
            rd_cnt_q <= rd_cnt_d;
            wr_cnt_q <= wr_cnt_d;
        end
    end

    assign rd_cnt_o = rd_cnt_q;
    assign wr_cnt_o = wr_cnt_q;
`else
    assign rd_cnt_o = '0;
    assign wr_cnt_o = '0;
`endif

    assign rd_eot_evt_o = rd_evt_q;
    assign wr_eot_evt_o = wr_evt_q;
    assign err_evt_o    = err_evt_q;
    assign pending_o    = occ_q;
    assign status_o     = status_q;

endmodule

// File: tb/tb_hyper_eot_tracker.sv
// ---------------------------------------------------------------------------
// tb_hyper_eot_tracker
//
// Purpose:
//   Self-checking bench for hyper_eot_tracker. Two instances share one set
//   of inputs: one with the default 16-bit counters and one with 2-bit
//   counters to exercise saturation. A queue-based reference model tracks
//   the expected outputs; directed scenarios are followed by random traffic.
// ---------------------------------------------------------------------------
module tb_hyper_eot_tracker;

    localparam int DEPTH  = 4;
    localparam int CNT_W  = 16;
    localparam int SAT_W  = 2;
    localparam int OW     = $clog2(DEPTH) + 1;

`ifdef HYPER_EOT_TRACK_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic sys_clk_i = 1'b0;
    always #5 sys_clk_i = ~sys_clk_i;

    logic rst_i, rx_start_evt_i, tx_start_evt_i, eot_i, clr_i;

    logic             rd_eot_evt_o, wr_eot_evt_o, err_evt_o;
    logic [OW-1:0]    pending_o;
    logic [CNT_W-1:0] rd_cnt_o, wr_cnt_o;
    logic [1:0]       status_o;

    logic             s_rd_eot_evt_o, s_wr_eot_evt_o, s_err_evt_o;
    logic [OW-1:0]    s_pending_o;
    logic [SAT_W-1:0] s_rd_cnt_o, s_wr_cnt_o;
    logic [1:0]       s_status_o;

    hyper_eot_tracker #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .sys_clk_i      (sys_clk_i),
        .rst_i          (rst_i),
        .rx_start_evt_i (rx_start_evt_i),
        .tx_start_evt_i (tx_start_evt_i),
        .eot_i          (eot_i),
        .clr_i          (clr_i),
        .rd_eot_evt_o   (rd_eot_evt_o),
        .wr_eot_evt_o   (wr_eot_evt_o),
        .err_evt_o      (err_evt_o),
        .pending_o      (pending_o),
        .rd_cnt_o       (rd_cnt_o),
        .wr_cnt_o       (wr_cnt_o),
        .status_o       (status_o)
    );

    hyper_eot_tracker #(.DEPTH(DEPTH), .CNT_W(SAT_W)) dut_sat (
        .sys_clk_i      (sys_clk_i),
        .rst_i          (rst_i),
        .rx_start_evt_i (rx_start_evt_i),
        .tx_start_evt_i (tx_start_evt_i),
        .eot_i          (eot_i),
        .clr_i          (clr_i),
        .rd_eot_evt_o   (s_rd_eot_evt_o),
        .wr_eot_evt_o   (s_wr_eot_evt_o),
        .err_evt_o      (s_err_evt_o),
        .pending_o      (s_pending_o),
        .rd_cnt_o       (s_rd_cnt_o),
        .wr_cnt_o       (s_wr_cnt_o),
        .status_o       (s_status_o)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state: ordered list of outstanding directions.
    bit          mq[$];
    int unsigned m_rd, m_wr;
    bit          m_ovf, m_orph;
    bit          e_rd, e_wr, e_err;

    function automatic logic [31:0] exp_cnt(input int unsigned v, input int w);
        int unsigned max_v;
        max_v = (32'd1 << w) - 1;
        if (!CNT_EN) return 32'd0;
        return (v > max_v) ? max_v : v;
    endfunction

    // One clock of behaviour: pop first (freeing a slot), then try the read
    // push, then the write push, each only if a slot remains.
    function automatic void model_step(input bit r, input bit x, input bit t,
                                       input bit e, input bit c);
        bit ovf;
        bit head;
        ovf   = 1'b0;
        e_rd  = 1'b0;
        e_wr  = 1'b0;
        e_err = 1'b0;
        if (r || c) begin
            mq.delete();
            m_rd   = 0;
            m_wr   = 0;
            m_ovf  = 1'b0;
            m_orph = 1'b0;
        end else begin
            if (e) begin
                if (mq.size() == 0) begin
                    m_orph = 1'b1;
                    e_err  = 1'b1;
                end else begin
                    head = mq.pop_front();
                    if (head) begin
                        e_rd = 1'b1;
                        m_rd++;
                    end else begin
                        e_wr = 1'b1;
                        m_wr++;
                    end
                end
            end
            if (x) begin
                if (mq.size() < DEPTH) mq.push_back(1'b1);
                else ovf = 1'b1;
            end
            if (t) begin
                if (mq.size() < DEPTH) mq.push_back(1'b0);
                else ovf = 1'b1;
            end
            if (ovf) begin
                m_ovf = 1'b1;
                e_err = 1'b1;
            end
        end
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        chk("rd_evt",    32'(rd_eot_evt_o), 32'(e_rd));
        chk("wr_evt",    32'(wr_eot_evt_o), 32'(e_wr));
        chk("err_evt",   32'(err_evt_o),    32'(e_err));
        chk("pending",   32'(pending_o),    32'(mq.size()));
        chk("status",    32'(status_o),     32'({m_orph, m_ovf}));
        chk("rd_cnt",    32'(rd_cnt_o),     exp_cnt(m_rd, CNT_W));
        chk("wr_cnt",    32'(wr_cnt_o),     exp_cnt(m_wr, CNT_W));
        chk("s_rd_cnt",  32'(s_rd_cnt_o),   exp_cnt(m_rd, SAT_W));
        chk("s_wr_cnt",  32'(s_wr_cnt_o),   exp_cnt(m_wr, SAT_W));
        chk("s_events",  32'({s_rd_eot_evt_o, s_wr_eot_evt_o, s_err_evt_o}),
                         32'({e_rd, e_wr, e_err}));
        chk("s_pending", 32'(s_pending_o),  32'(mq.size()));
        chk("s_status",  32'(s_status_o),   32'({m_orph, m_ovf}));
    endtask

    // Drive one cycle of inputs, advance past the edge, then compare.
    task automatic step(input bit r, input bit x, input bit t, input bit e, input bit c);
        rst_i          = r;
        rx_start_evt_i = x;
        tx_start_evt_i = t;
        eot_i          = e;
        clr_i          = c;
        @(posedge sys_clk_i);
        model_step(r, x, t, e, c);
        #1;
        check_model();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
    endtask

    initial begin
        rst_i = 1'b1; rx_start_evt_i = 1'b0; tx_start_evt_i = 1'b0;
        eot_i = 1'b0; clr_i = 1'b0;

        // Reset state.
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        chk("rst_pending", 32'(pending_o), 32'd0);
        chk("rst_status",  32'(status_o),  32'd0);

        // Single read, eot after 10 cycles.
        step(0, 1, 0, 0, 0);
        chk("s1_pending1", 32'(pending_o), 32'd1);
        idle(10);
        step(0, 0, 0, 1, 0);
        chk("s1_rd_pulse", 32'(rd_eot_evt_o), 32'd1);
        chk("s1_wr_quiet", 32'(wr_eot_evt_o), 32'd0);
        chk("s1_pending0", 32'(pending_o),    32'd0);
        idle(1);
        chk("s1_rd_once",  32'(rd_eot_evt_o), 32'd0);

        // Mixed order tx, rx, tx then three eots.
        step(0, 0, 1, 0, 0);
        step(0, 1, 0, 0, 0);
        step(0, 0, 1, 0, 0);
        step(0, 0, 0, 1, 0);
        chk("s2_first_wr",  32'(wr_eot_evt_o), 32'd1);
        step(0, 0, 0, 1, 0);
        chk("s2_second_rd", 32'(rd_eot_evt_o), 32'd1);
        step(0, 0, 0, 1, 0);
        chk("s2_third_wr",  32'(wr_eot_evt_o), 32'd1);
        idle(1);

        // Overflow: three reads then rx+tx together with one slot left.
        step(0, 0, 0, 0, 1);
        step(0, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        step(0, 1, 1, 0, 0);
        chk("s3_status",  32'(status_o),  32'd1);
        chk("s3_err",     32'(err_evt_o), 32'd1);
        chk("s3_pending", 32'(pending_o), 32'(DEPTH));

        // Full queue, eot and tx together: no overflow, tail becomes write.
        step(0, 0, 1, 1, 0);
        chk("s4_no_err",  32'(err_evt_o),    32'd0);
        chk("s4_rd_head", 32'(rd_eot_evt_o), 32'd1);
        chk("s4_pending", 32'(pending_o),    32'(DEPTH));
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 1, 0);
        chk("s4_tail_wr", 32'(wr_eot_evt_o), 32'd1);

        // Orphan eot, then clr together with rx start.
        step(0, 0, 0, 1, 0);
        chk("s5_err",     32'(err_evt_o),                      32'd1);
        chk("s5_orphan",  32'(status_o[1]),                    32'd1);
        chk("s5_no_rdwr", 32'({rd_eot_evt_o, wr_eot_evt_o}),   32'd0);
        step(0, 1, 0, 1, 1);
        chk("s5_clr_stat", 32'(status_o),  32'd0);
        chk("s5_clr_pend", 32'(pending_o), 32'd0);
        chk("s5_clr_evts", 32'({rd_eot_evt_o, wr_eot_evt_o, err_evt_o}), 32'd0);

        // Five read completions: the 2-bit counters stick at 3.
        for (int i = 0; i < 5; i++) begin
            step(0, 1, 0, 0, 0);
            step(0, 0, 0, 1, 0);
        end
        chk("s6_sat", 32'(s_rd_cnt_o), CNT_EN ? 32'd3 : 32'd0);
        chk("s6_full", 32'(rd_cnt_o),  CNT_EN ? 32'd5 : 32'd0);

        // Eot in the cycle right after a mid-operation reset is an orphan.
        step(0, 1, 1, 0, 0);
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0);
        chk("s7_orphan", 32'(status_o), 32'd2);

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 199) == 0,
                 $urandom_range(0, 99) < 40,
                 $urandom_range(0, 99) < 40,
                 $urandom_range(0, 99) < 45,
                 $urandom_range(0, 99) < 2);
        end
        idle(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
